alu_share_sched: RTL

//  Shares one combinational AlU_Nbit between two requesters via a round-robin arbiter.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_share_sched_if.sv | 30 +++
 rtl/AlU_Nbit.sv | 71 +++++++
 rtl/alu_share_sched_rr_arb2.sv | 19 +
 rtl/alu_share_sched.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU scheduler: widths, opcode map,
// FSM encoding and the flag bundle returned with every result.
package alu_pkg;

    localparam int DEF_BUS_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 8;

    localparam logic [3:0] OP_ADD       = 4'd0;
    localparam logic [3:0] OP_SUB       = 4'd1;
    localparam logic [3:0] OP_AND       = 4'd2;
    localparam logic [3:0] OP_OR        = 4'd3;
    localparam logic [3:0] OP_XOR       = 4'd4;
    localparam logic [3:0] OP_NOT       = 4'd5;
    localparam logic [3:0] OP_SHL       = 4'd6;
    localparam logic [3:0] OP_SHR       = 4'd7;
    localparam logic [3:0] OP_INC       = 4'd8;
    localparam logic [3:0] OP_DEC       = 4'd9;
    localparam logic [3:0] OP_MAX_VALID = OP_DEC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Bit order matches the rsp_flags port: {carry_out, borrow, zero, parity, invalid_op}
    typedef struct packed {
        logic carry_out;
        logic borrow;
        logic zero;
        logic parity;
        logic invalid_op;
    } alu_flags_t;

    function automatic logic op_is_invalid(input logic [3:0] op);
        return op > OP_MAX_VALID;
    endfunction

endpackage

// File: rtl/alu_share_sched_if.sv
// Request/response bundle between the two issuers, the response consumer
// and the shared-ALU scheduler.
interface alu_share_sched_if #(
    parameter int BUS_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [2*BUS_WIDTH-1:0] req_a;
    logic [2*BUS_WIDTH-1:0] req_b;
    logic [1:0]             req_cin;
    logic [7:0]             req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [BUS_WIDTH-1:0]   rsp_y;
    logic [4:0]             rsp_flags;
    logic [CNT_WIDTH-1:0]   invalid_cnt;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_flags, invalid_cnt, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_flags, invalid_cnt, busy
    );
endinterface

// File: rtl/AlU_Nbit.sv
// Combinational N-bit ALU: ten operations plus carry/borrow/zero/parity flags.
// Opcodes above OP_MAX_VALID produce y=0 and raise invalid_op.
module AlU_Nbit
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic [3:0]           opcode,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 zero,
    output logic                 parity,
    output logic                 invalid_op
);

    logic [BUS_WIDTH:0] ext;
    logic [BUS_WIDTH:0] cin_ext;

    assign cin_ext = {{BUS_WIDTH{1'b0}}, carry_in};

    always_comb begin
        ext       = '0;
        y         = '0;
        carry_out = 1'b0;
        borrow    = 1'b0;
        case (opcode)
            OP_ADD: begin
                ext       = {1'b0, a} + {1'b0, b} + cin_ext;
                y         = ext[BUS_WIDTH-1:0];
                carry_out = ext[BUS_WIDTH];
            end
            // The extra top bit of the widened difference is the borrow
            OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b} - cin_ext;
                y      = ext[BUS_WIDTH-1:0];
                borrow = ext[BUS_WIDTH];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y         = {a[BUS_WIDTH-2:0], 1'b0};
                carry_out = a[BUS_WIDTH-1];
            end
            OP_SHR: begin
                y         = {1'b0, a[BUS_WIDTH-1:1]};
                carry_out = a[0];
            end
            OP_INC: begin
                ext       = {1'b0, a} + (BUS_WIDTH+1)'(1);
                y         = ext[BUS_WIDTH-1:0];
                carry_out = ext[BUS_WIDTH];
            end
            OP_DEC: begin
                ext    = {1'b0, a} - (BUS_WIDTH+1)'(1);
                y      = ext[BUS_WIDTH-1:0];
                borrow = ext[BUS_WIDTH];
            end
            default: y = '0;
        endcase
        zero       = (y == '0);
        parity     = ^y;
        invalid_op = op_is_invalid(opcode);
    end

endmodule

// File: rtl/alu_share_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester named by prio wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one AlU_Nbit between two requesters: IDLE grants and captures
// operands, EXEC latches the ALU result, RESP holds it until consumed.
module alu_share_sched
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input logic              clk,
    input logic              rst,
    alu_share_sched_if.slave bus
);

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 id_q, id_d;
    logic [BUS_WIDTH-1:0] a_q, a_d;
    logic [BUS_WIDTH-1:0] b_q, b_d;
    logic                 cin_q, cin_d;
    logic [3:0]           op_q, op_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [BUS_WIDTH-1:0] rsp_y_q, rsp_y_d;
    alu_flags_t           rsp_flags_q, rsp_flags_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    logic [1:0]           grant;
    logic                 gid;
    logic [BUS_WIDTH-1:0] alu_y;
    alu_flags_t           alu_flags;

    rr_arb2 u_arb (
        .req   (bus.req_valid),
        .prio  (prio_q),
        .grant (grant)
    );

    AlU_Nbit #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
        .a          (a_q),
        .b          (b_q),
        .carry_in   (cin_q),
        .opcode     (op_q),
        .y          (alu_y),
        .carry_out  (alu_flags.carry_out),
        .borrow     (alu_flags.borrow),
        .zero       (alu_flags.zero),
        .parity     (alu_flags.parity),
        .invalid_op (alu_flags.invalid_op)
    );

    assign gid = grant[1];

    // Grants are only visible while IDLE; a waiting request simply stays pending
    assign bus.req_ready   = (state_q == S_IDLE) ? grant : 2'b00;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_y       = rsp_y_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.invalid_cnt = cnt_q;
    assign bus.busy        = busy_q;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    a_d     = gid ? bus.req_a[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_a[BUS_WIDTH-1:0];
                    b_d     = gid ? bus.req_b[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_b[BUS_WIDTH-1:0];
                    cin_d   = bus.req_cin[gid];
                    op_d    = gid ? bus.req_op[7:4] : bus.req_op[3:0];
                    id_d    = gid;
                    prio_d  = ~gid;
                    busy_d  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_y_d     = alu_y;
                rsp_flags_d = alu_flags;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                if (alu_flags.invalid_op && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                state_d = S_RESP;
            end
            // Result registers are deliberately left holding the last response
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

endmodule
